// File: rtl/key_input.sv
// Key conditioning for the hack uc: synchronise, debounce, count presses, sticky flags at 0x7400..0x7402.
// Optional sticky release flags in reg0x7402[8+i] are built only when KEY_RELEASE_FLAGS_EN is defined.
module key_input #(
  parameter int NK         = 4,
  parameter int AW         = 15,
  parameter int DW         = 16,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic          clk50m,
  input  logic          rst_n,
  input  logic [NK-1:0] keys_n,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] reg0x7400,
  output logic [DW-1:0] reg0x7401,
  output logic [DW-1:0] reg0x7402
);

  localparam int            CW       = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CYCLES - 1);
  localparam logic [AW-1:0] CNT_ADDR = AW'(15'h7401);
  localparam logic [AW-1:0] FLG_ADDR = AW'(15'h7402);

  logic [NK-1:0] meta_reg, sync_reg;
  logic [NK-1:0] deb;
  logic [NK-1:0] rise;
  logic [DW-1:0] ev_reg, ev_next;
  logic [NK-1:0] flag_reg, flag_next, flag_clr;
  logic          cnt_wr, flag_wr, any_press;
  logic          data_unused;

`ifdef KEY_RELEASE_FLAGS_EN
  logic [NK-1:0] fall;
  logic [NK-1:0] rel_reg, rel_next, rel_clr;
`endif

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= ~keys_n;
      sync_reg <= meta_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NK; gi++) begin : g_deb
      logic [CW-1:0] cnt_reg, cnt_next;
      logic          deb_reg, deb_next;

      // The level only moves after the synchronised input has disagreed for DEB_CYCLES edges in a row.
      always_comb begin
        cnt_next = cnt_reg;
        deb_next = deb_reg;
        if (sync_reg[gi] == deb_reg) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_MAX) begin
          deb_next = sync_reg[gi];
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
          deb_reg <= 1'b0;
        end else begin
          cnt_reg <= cnt_next;
          deb_reg <= deb_next;
        end
      end

      assign deb[gi]  = deb_reg;
      assign rise[gi] = deb_next & ~deb_reg;
`ifdef KEY_RELEASE_FLAGS_EN
      assign fall[gi] = deb_reg & ~deb_next;
`endif
    end
  endgenerate

  assign cnt_wr    = we && (addr == CNT_ADDR);
  assign flag_wr   = we && (addr == FLG_ADDR);
  assign any_press = |rise;
  assign flag_clr  = flag_wr ? data_in[NK-1:0] : '0;
  assign data_unused = ^data_in;

  // A clear coinciding with a press leaves that press counted.
  always_comb begin
    ev_next = ev_reg;
    if (cnt_wr) begin
      ev_next = any_press ? DW'(1) : '0;
    end else if (any_press) begin
      ev_next = ev_reg + DW'(1);
    end
  end

  assign flag_next = (flag_reg & ~flag_clr) | rise;

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      ev_reg   <= '0;
      flag_reg <= '0;
    end else begin
      ev_reg   <= ev_next;
      flag_reg <= flag_next;
    end
  end

  assign reg0x7400 = DW'(deb);
  assign reg0x7401 = ev_reg;

`ifdef KEY_RELEASE_FLAGS_EN
  assign rel_clr  = flag_wr ? data_in[8 +: NK] : '0;
  assign rel_next = (rel_reg & ~rel_clr) | fall;

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      rel_reg <= '0;
    end else begin
      rel_reg <= rel_next;
    end
  end

  always_comb begin
    reg0x7402           = '0;
    reg0x7402[NK-1:0]   = flag_reg;
    reg0x7402[8 +: NK]  = rel_reg;
  end
`else
  assign reg0x7402 = DW'(flag_reg);
`endif

endmodule

// File: tb/tb_key_input.sv
// Directed bench for key_input with DEB_CYCLES=4, NK=4; expected register values are hand-computed.
// Works with and without KEY_RELEASE_FLAGS_EN defined.
module tb_key_input;
  localparam int NK = 4;
  localparam int AW = 15;
  localparam int DW = 16;
  localparam int DEB = 4;
`ifdef KEY_RELEASE_FLAGS_EN
  localparam logic [15:0] REL_ON = 16'hFFFF;
`else
  localparam logic [15:0] REL_ON = 16'h0000;
`endif

  logic          clk50m = 1'b0;
  logic          rst_n;
  logic [NK-1:0] keys_n;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] reg0x7400, reg0x7401, reg0x7402;

  int n_tests = 0;
  int n_fail  = 0;

  key_input #(.NK(NK), .AW(AW), .DW(DW), .DEB_CYCLES(DEB)) dut (
    .clk50m(clk50m), .rst_n(rst_n), .keys_n(keys_n), .we(we), .addr(addr),
    .data_in(data_in), .reg0x7400(reg0x7400), .reg0x7401(reg0x7401), .reg0x7402(reg0x7402)
  );

  always #10 clk50m = ~clk50m;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [15:0] lvl, input logic [15:0] cnt,
                           input logic [15:0] flg);
    check({tag, "_lvl"}, reg0x7400, lvl);
    check({tag, "_cnt"}, reg0x7401, cnt);
    check({tag, "_flg"}, reg0x7402, flg);
    $display("[TB] %s: lvl=0x%04h cnt=0x%04h flg=0x%04h", tag, reg0x7400, reg0x7401, reg0x7402);
  endtask

  // Expected flag register from press-flag bits p and release-flag bits r.
  function automatic logic [15:0] fl(input logic [3:0] p, input logic [3:0] r);
    return ((16'(r) << 8) & REL_ON) | 16'(p);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk50m);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; addr = a; data_in = d;
    tick(1);
    we = 1'b0; addr = '0; data_in = '0;
  endtask

  initial begin
    rst_n = 1'b0; keys_n = 4'hF; we = 1'b0; addr = '0; data_in = '0;
    tick(2);
    check_all("reset", 16'h0000, 16'h0000, 16'h0000);

    // Key 0 press: level appears exactly 6 edges after the raw change.
    rst_n = 1'b1; keys_n = 4'b1110;
    tick(5);
    check("press0_early", reg0x7400, 16'h0000);
    tick(1);
    check_all("press0", 16'h0001, 16'h0001, fl(4'h1, 4'h0));

    // 3-cycle glitch on key 1 is absorbed.
    keys_n = 4'b1100;
    tick(3);
    keys_n = 4'b1110;
    tick(6);
    check_all("glitch1", 16'h0001, 16'h0001, fl(4'h1, 4'h0));

    // Asynchronous reset with key 0 still held.
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 16'h0000, 16'h0000, 16'h0000);
    tick(1);
    rst_n = 1'b1;
    tick(5);
    check("rst_rel_early", reg0x7400, 16'h0000);
    tick(1);
    check_all("rst_rel", 16'h0001, 16'h0001, fl(4'h1, 4'h0));

    // Keys 1 and 2 on the same edge count once.
    keys_n = 4'b1000;
    tick(6);
    check_all("simul12", 16'h0007, 16'h0002, fl(4'h7, 4'h0));

    wr(15'h7402, 16'h0005);
    check_all("w1c_0005", 16'h0007, 16'h0002, fl(4'h2, 4'h0));

    wr(15'h7403, 16'hFFFF);
    wr(15'h7400, 16'hFFFF);
    check_all("other_addr", 16'h0007, 16'h0002, fl(4'h2, 4'h0));

    // Release key 0: only the level (and optional release flag) changes.
    keys_n = 4'b1001;
    tick(6);
    check_all("release0", 16'h0006, 16'h0002, fl(4'h2, 4'h1));

    // Re-press key 0 with a clear of flag bit 0 on the same edge: set wins.
    keys_n = 4'b1000;
    tick(5);
    check("repress0_early", reg0x7400, 16'h0006);
    wr(15'h7402, 16'h0001);
    check_all("set_wins", 16'h0007, 16'h0003, fl(4'h3, 4'h1));

    // Press key 3 with a counter clear on the same edge.
    keys_n = 4'b0000;
    tick(5);
    wr(15'h7401, 16'h1234);
    check_all("clr_press", 16'h000F, 16'h0001, fl(4'hB, 4'h1));

    // Release key 2, then clear both release flags by W1C.
    keys_n = 4'b0100;
    tick(6);
    check_all("release2", 16'h000B, 16'h0001, fl(4'hB, 4'h5));
    wr(15'h7402, 16'h0500);
    check_all("rel_w1c", 16'h000B, 16'h0001, fl(4'hB, 4'h0));

    // Counter wrap from a forced 0xFFFF.
    force dut.ev_reg = 16'hFFFF;
    #1;
    release dut.ev_reg;
    tick(1);
    check("preload", reg0x7401, 16'hFFFF);
    keys_n = 4'b0000;
    tick(6);
    check_all("wrap", 16'h000F, 16'h0000, fl(4'hF, 4'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
